clk_enable_gen: RTL and testbench

Parametrised multi-channel clock-enable generator. It produces NUM_CH single-cycle enable strobes from one system clock. Each channel has a runtime-programmable divide ratio and phase offset, and a PLL-style locked indication. Downstream blocks that currently need extra PLL output clocks run on refclk and qualify with ce_out instead, which removes clock-domain crossings.

---
 rtl/clk_enable_gen_pkg.sv | 21 ++
 rtl/clk_enable_gen_if.sv | 30 +++
 rtl/clk_enable_chan.sv | 43 ++++
 rtl/clk_enable_gen.sv | 121 ++++++++++++
 tb/tb_clk_enable_gen.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/clk_enable_gen_pkg.sv
// Shared types, widths and helpers for the multi-channel clock-enable generator.
package clk_enable_gen_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SETTLE = 2'd2
    } state_e;

    localparam int unsigned SETTLE_CYC_DEF = 16;
    localparam int unsigned SETTLE_W       = $clog2(SETTLE_CYC_DEF + 1);

    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned settle_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/clk_enable_gen_if.sv
// Config / sync / enable-strobe bundle between a controller and clk_enable_gen.
interface clk_enable_gen_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned DIV_W  = 16
);
    import clk_enable_gen_pkg::*;

    localparam int unsigned CH_W = ch_w(NUM_CH);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [DIV_W-1:0]  cfg_phase;
    logic              cfg_err;
    logic              sync_req;
    logic [NUM_CH-1:0] ce_out;
    logic              locked;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_phase, sync_req,
        input  cfg_ready, cfg_err, ce_out, locked
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_phase, sync_req,
        output cfg_ready, cfg_err, ce_out, locked
    );

endinterface

// File: rtl/clk_enable_chan.sv
// One enable channel: free-running modulo-div counter with a registered phase compare.
module clk_enable_chan #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [DIV_W-1:0] div_in,
    input  logic [DIV_W-1:0] phase_in,
    input  logic             ce_en,
    output logic             ce
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] phase;

    // Compare uses the pre-update counter/phase, giving one cycle of strobe latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            div   <= DIV_W'(DEFAULT_DIV);
            phase <= '0;
            ce    <= 1'b0;
        end else begin
            ce <= (cnt == phase) && ce_en;
            if (load) begin
                div   <= div_in;
                phase <= phase_in;
            end
            if (clear) begin
                cnt <= '0;
            end else if (cnt == div - DIV_W'(1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator with config/realign FSM and lock indication.
// Optional build macro CLK_EN_GATE_UNLOCKED_EN: suppress ce_out while not locked.
module clk_enable_gen
    import clk_enable_gen_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 2,
    parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF
) (
    input  logic           refclk,
    input  logic           rst_n,
    clk_enable_gen_if.slave bus
);

    localparam int unsigned CH_W   = ch_w(NUM_CH);
    localparam int unsigned SCNT_W = (settle_w(SETTLE_CYC) > SETTLE_W) ? settle_w(SETTLE_CYC) : SETTLE_W;

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_APPLY  = 2'(APPLY);
    localparam logic [1:0] ST_SETTLE = 2'(SETTLE);

    logic [1:0]        state, state_nxt;
    logic [SCNT_W-1:0] scnt, scnt_nxt;
    logic              accept, bad, take, idle_nxt, apply_c, ce_en;
    logic              ready_q, locked_q, err_q;
    logic              pend_vld;
    logic [CH_W-1:0]   pend_ch;
    logic [DIV_W-1:0]  pend_div, pend_phase;
    logic [NUM_CH-1:0] ce_vec;

    // Next-state: accept/reject in IDLE, single APPLY cycle, fixed-length SETTLE.
    always_comb begin
        state_nxt = state;
        scnt_nxt  = '0;
        accept    = 1'b0;
        take      = 1'b0;
        bad       = (bus.cfg_div == '0) || (bus.cfg_phase >= bus.cfg_div) ||
                    (32'(bus.cfg_ch) >= NUM_CH);
        case (state)
            ST_IDLE: begin
                accept = bus.cfg_valid;
                take   = bus.cfg_valid && !bad;
                if (take || bus.sync_req) begin
                    state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (scnt == SCNT_W'(SETTLE_CYC - 1)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    scnt_nxt = scnt + SCNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_SETTLE;
            end
        endcase
    end

    assign idle_nxt = (state_nxt == ST_IDLE);
    assign apply_c  = (state == ST_APPLY);

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state      <= ST_SETTLE;
            scnt       <= '0;
            ready_q    <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            pend_vld   <= 1'b0;
            pend_ch    <= '0;
            pend_div   <= '0;
            pend_phase <= '0;
        end else begin
            state    <= state_nxt;
            scnt     <= scnt_nxt;
            ready_q  <= idle_nxt;
            locked_q <= idle_nxt;
            err_q    <= accept && bad;
            // Only IDLE can set take, so pend_vld is meaningful exactly during APPLY.
            pend_vld <= take;
            if (take) begin
                pend_ch    <= bus.cfg_ch;
                pend_div   <= bus.cfg_div;
                pend_phase <= bus.cfg_phase;
            end
        end
    end

`ifdef CLK_EN_GATE_UNLOCKED_EN
    assign ce_en = idle_nxt;
`else
    assign ce_en = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_enable_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk      (refclk),
            .rst_n    (rst_n),
            .clear    (apply_c),
            .load     (apply_c && pend_vld && (pend_ch == CH_W'(i))),
            .div_in   (pend_div),
            .phase_in (pend_phase),
            .ce_en    (ce_en),
            .ce       (ce_vec[i])
        );
    end

    assign bus.cfg_ready = ready_q;
    assign bus.locked    = locked_q;
    assign bus.cfg_err   = err_q;
    assign bus.ce_out    = ce_vec;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Randomized + directed bench for clk_enable_gen against an edge-indexed timeline model.
module tb_clk_enable_gen;

    localparam int NUM_CH     = 3;
    localparam int DIV_W      = 16;
    localparam int CH_W       = 2;
    localparam int SETTLE_CYC = 16;

    logic refclk = 1'b0;
    logic rst_n;

    always #5 refclk = ~refclk;

    clk_enable_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    clk_enable_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (2),
        .SETTLE_CYC  (SETTLE_CYC)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: channel i's counter after edge t is (t - align) mod div[i].
    int              edge_n   = 0;
    bit              m_locked = 1'b0;
    int              lock_at  = 32'h3fff_ffff;
    int              align    = 0;
    int              apply_at = 0;
    bit              apply_pend = 1'b0;
    bit              pw_vld   = 1'b0;
    int              pw_ch, pw_div, pw_ph;
    int              mdiv [NUM_CH];
    int              mph  [NUM_CH];
    logic [NUM_CH-1:0] exp_ce  = '0;
    bit              exp_err = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_step();
        bit was_locked;
        bit bad;
        int c_ch, c_div, c_ph;
        edge_n++;
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mdiv[i] = 2;
                mph[i]  = 0;
            end
            align      = edge_n;
            lock_at    = edge_n + SETTLE_CYC;
            m_locked   = 1'b0;
            apply_pend = 1'b0;
            pw_vld     = 1'b0;
            exp_ce     = '0;
            exp_err    = 1'b0;
            return;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            exp_ce[i] = (((edge_n - 1 - align) % mdiv[i]) == mph[i]);
        end
        was_locked = m_locked;
        exp_err    = 1'b0;
        c_ch  = int'(bus.cfg_ch);
        c_div = int'(bus.cfg_div);
        c_ph  = int'(bus.cfg_phase);
        if (was_locked) begin
            bad     = (c_div == 0) || (c_ph >= c_div) || (c_ch >= NUM_CH);
            exp_err = bus.cfg_valid && bad;
            pw_vld  = bus.cfg_valid && !bad;
            pw_ch   = c_ch;
            pw_div  = c_div;
            pw_ph   = c_ph;
            if (pw_vld || bus.sync_req) begin
                apply_pend = 1'b1;
                apply_at   = edge_n + 1;
                lock_at    = edge_n + 1 + SETTLE_CYC;
            end
        end else if (apply_pend && edge_n == apply_at) begin
            if (pw_vld) begin
                mdiv[pw_ch] = pw_div;
                mph[pw_ch]  = pw_ph;
            end
            align      = edge_n;
            apply_pend = 1'b0;
        end
        m_locked = (edge_n >= lock_at);
`ifdef CLK_EN_GATE_UNLOCKED_EN
        if (!m_locked) exp_ce = '0;
`endif
    endtask

    task automatic tick();
        @(posedge refclk);
        model_step();
        #1;
        check_eq("locked",    32'(bus.locked),    32'(m_locked));
        check_eq("cfg_ready", 32'(bus.cfg_ready), 32'(m_locked));
        check_eq("cfg_err",   32'(bus.cfg_err),   32'(exp_err));
        check_eq("ce_out",    32'(bus.ce_out),    32'(exp_ce));
    endtask

    task automatic drive(input bit r, input bit v, input int ch, input int dv, input int ph, input bit s);
        rst_n         = r;
        bus.cfg_valid = v;
        bus.cfg_ch    = CH_W'(ch);
        bus.cfg_div   = DIV_W'(dv);
        bus.cfg_phase = DIV_W'(ph);
        bus.sync_req  = s;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        int rv, dv;
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        idle(30);
        // Valid reconfig of channel 1.
        drive(1'b1, 1'b1, 1, 5, 3, 1'b0);
        idle(40);
        // Rejected configs: zero div, phase == div, channel out of range.
        drive(1'b1, 1'b1, 0, 0, 0, 1'b0);
        idle(5);
        drive(1'b1, 1'b1, 2, 4, 4, 1'b0);
        idle(5);
        drive(1'b1, 1'b1, 3, 3, 1, 1'b0);
        idle(5);
        // Divide-by-one channel.
        drive(1'b1, 1'b1, 0, 1, 0, 1'b0);
        idle(25);
        // Periods 2/5/7 then a pure realignment, with a sync during SETTLE.
        drive(1'b1, 1'b1, 0, 2, 1, 1'b0);
        idle(20);
        drive(1'b1, 1'b1, 2, 7, 6, 1'b0);
        idle(23);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
        idle(5);
        drive(1'b1, 1'b0, 0, 0, 0, 1'b1);
        idle(20);
        // Rejected config coincident with sync, then valid config with sync.
        drive(1'b1, 1'b1, 1, 3, 5, 1'b1);
        idle(20);
        drive(1'b1, 1'b1, 1, 4, 2, 1'b1);
        idle(20);
        // Reset in the middle of SETTLE after a config.
        drive(1'b1, 1'b1, 2, 3, 2, 1'b0);
        idle(5);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
        idle(30);
        // Random traffic.
        repeat (1500) begin
            rv = $urandom_range(0, 999);
            dv = $urandom_range(0, 9);
            if (rv < 6) begin
                drive(1'b0, 1'b0, 0, 0, 0, 1'b0);
            end else begin
                drive(1'b1, (rv % 8) == 0, $urandom_range(0, 3), dv,
                      $urandom_range(0, dv + 1), (rv % 23) == 0);
            end
        end
        idle(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
